// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver with mid-bit sampling and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; default build uses a single holding register.
module uart_rx_frame #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_en_i,
  input  logic                          uart_rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int BAUD_DIV = CLK_HZ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_END = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             rx_meta, rx_sync, rx_prev;
  logic             push, pop, full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // The stop sample and the buffer write happen on the same edge.
  assign push = rx_en_i && (state_q == STOP) && (cnt_q == FULL_END) && rx_sync;
  assign pop  = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (!rx_en_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (rx_prev && !rx_sync) begin
            state_q <= START;
            cnt_q   <= '0;
          end
          START: if (cnt_q == HALF_END) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_sync ? IDLE : DATA;
          end else cnt_q <= cnt_q + CNT_W'(1);
          DATA: if (cnt_q == FULL_END) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else cnt_q <= cnt_q + CNT_W'(1);
          STOP: if (cnt_q == FULL_END) begin
            cnt_q       <= '0;
            state_q     <= IDLE;
            frame_err_o <= !rx_sync;
          end else cnt_q <= cnt_q + CNT_W'(1);
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) overflow_o <= 1'b0;
    else       overflow_o <= push && full && !pop;
  end

`ifdef UART_RX_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          wr;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign wr      = push && (!full || pop);
  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rptr_q] : 8'h00;
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr)  wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
      case ({wr, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       full_q;

  assign full    = full_q;
  assign valid_o = full_q;
  assign data_o  = hold_q;
  assign count_o = CW'(full_q);

  // A push into a full register is taken only when the current byte leaves the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else if (push && (!full_q || pop)) begin
      hold_q <= shift_q;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end
`endif
endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, core clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate; BAUD_DIV = CLK_HZ/BAUD_RATE (integer, 868 at defaults); HALF_DIV = BAUD_DIV/2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive buffer entries, power of two.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_en_i  input  1  receiver enable.
REQ-007 SHALL have port uart_rx_i  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port data_o  output  8  byte at buffer head.
REQ-009 SHALL have port valid_o  output  1  data_o holds an unread byte.
REQ-010 SHALL have port ready_i  input  1  consumer accepts data_o this cycle.
REQ-011 SHALL have port frame_err_o  output  1  one-cycle pulse, bad stop bit.
REQ-012 SHALL have port overflow_o  output  1  one-cycle pulse, byte dropped because buffer full.
REQ-013 SHALL have port count_o  output  $clog2(FIFO_DEPTH)+1  buffered byte count.

Function
REQ-014 SHALL pass uart_rx_i through a 2-flop synchronizer, both flops resetting to 1; all decisions use the synchronized line (2-cycle input latency).
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP with a baud counter of width $clog2(BAUD_DIV).
REQ-016 IDLE: SHALL enter START and clear the counter on a synchronized falling edge (previous 1, current 0) while rx_en_i=1.
REQ-017 START: at counter == HALF_DIV-1, SHALL go to DATA if the line is 0, else return to IDLE silently (glitch rejection).
REQ-018 DATA: SHALL sample the line every BAUD_DIV cycles, shift LSB first, and enter STOP after the 8th bit.
REQ-019 STOP: after BAUD_DIV cycles, SHALL push the byte if the line is 1, else pulse frame_err_o and discard; SHALL return to IDLE in both cases.
REQ-020 A pushed byte SHALL appear at valid_o/data_o on the cycle after the stop sample when the buffer was empty.
REQ-021 Pop SHALL occur when valid_o=1 and ready_i=1; data_o SHALL then show the next entry on the following cycle, FIFO order.
REQ-022 A push when full with no pop SHALL drop the new byte and pulse overflow_o; a push while full with a simultaneous pop SHALL be accepted without overflow.
REQ-023 A simultaneous push and pop on a non-empty, non-full buffer SHALL leave count_o unchanged.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count_o SHALL range 0..FIFO_DEPTH.
REQ-025 rx_en_i=0 SHALL force the FSM to IDLE on the next edge and discard any partial byte; buffer contents and the pop path SHALL be unaffected.

Reset
REQ-026 On rst_i=1 at a clock edge: FSM=IDLE, counters 0, pointers 0, count_o=0, valid_o=0, data_o=8'h00, frame_err_o=0, overflow_o=0, synchronizer=1; a partial frame SHALL be discarded.

Configuration
REQ-027 Macro UART_RX_FIFO_EN defined: buffer SHALL be a FIFO_DEPTH-entry FIFO per REQ-021..024.
REQ-028 Macro UART_RX_FIFO_EN undefined: buffer SHALL be a single holding register (effective depth 1, count_o 0..1), FIFO_DEPTH ignored, full/pop/overflow rules of REQ-022 unchanged.

Verification
REQ-029 Frame of byte 0xCD at 868 cycles/bit, ready_i=1 -> exactly one valid_o pulse with data_o=0xCD about 8248 cycles after the start edge; no error pulses.
REQ-030 0 glitch of 200 cycles on an idle line -> no valid_o, no frame_err_o, FSM back in IDLE.
REQ-031 Frame 0x3C with stop bit 0 -> one frame_err_o pulse, count_o stays 0.
REQ-032 FIFO build, ready_i=0, bytes 0x00..0x08 sent -> count_o=8, one overflow_o pulse on the 9th; drain yields 0x00..0x07 in order.
REQ-033 rx_en_i dropped after 4 data bits, then a full 0x5A frame -> only 0x5A delivered.
REQ-034 rst_i asserted mid-frame with 3 bytes buffered -> next cycle count_o=0, valid_o=0, data_o=0x00; a subsequent 0xA5 frame is received correctly.
